rx_byte_fifo: RTL and testbench
===============================

// Module: rx_byte_fifo
// PURPOSE
//  Downstream consumer of the UART receive block. Drains the one-byte receive buffer via the
//  data_ready/data_read handshake into a DEPTH-entry FIFO, tagging each byte with overrun status.
//  Presents bytes to the host side on a first-word-fall-through valid/ready port.
//  Decouples host read latency from line rate so back-to-back frames do not cause overruns.
// PARAMETERS
//  DEPTH     8  FIFO entries; power of 2, >= 2
//  ADDR_W    $clog2(DEPTH)  pointer width (derived, not overridden)
//  ERR_CNT_W 8  width of error counters (only with RX_ERR_CNT_EN)
// PORTS
//  clk            in   1         system clock, all logic on rising edge
//  n_rst          in   1         asynchronous active-low reset
//  data_ready     in   1         receive buffer holds an unread byte
//  rx_data        in   8         receive buffer byte
//  overrun_error  in   1         receive buffer overwrote an unread byte
//  framing_error  in   1         stop bit check failed on current frame
//  data_read      out  1         one-cycle pulse: byte consumed from receive buffer
//  out_data       out  8         FIFO head byte (valid when out_valid)
//  out_err        out  1         overrun tag stored with head byte
//  out_valid      out  1         FIFO not empty
//  out_ready      in   1         host accepts head; pop when out_valid && out_ready
//  full           out  1         count == DEPTH
//  count          out  ADDR_W+1  entries held, 0..DEPTH
//  ferr_cnt, oerr_cnt  out ERR_CNT_W   error counters (RX_ERR_CNT_EN only)
//  cnt_clr        in   1         sync clear of error counters (RX_ERR_CNT_EN only)
// BEHAVIOUR
//  Reset: data_read=0, out_valid=0, full=0, count=0, out_data=0, out_err=0, pointers=0,
//   FSM=IDLE, counters=0. Reset mid-handshake abandons the byte; no partial write survives.
//  Capture FSM (Moore data_read):
//   IDLE: if data_ready && !full -> write {overrun_error, rx_data} at wr_ptr this edge, go READ.
//         if full, stay IDLE, no data_read; receive block is left to flag overrun itself.
//   READ: data_read=1 for exactly this cycle -> WAIT.
//   WAIT: stay until data_ready==0, then IDLE (no double capture of a stale byte).
//  Capture latency: data_ready high at edge N -> byte written at N, data_read high N..N+1.
//  Minimum 3 cycles per byte; far below one UART bit time.
//  Push/pop: push = IDLE && data_ready && !full; pop = out_valid && out_ready.
//   full sampled before the edge: when full, no push even if pop in same cycle.
//   push && pop same cycle -> count unchanged, both pointers advance.
//   pop when empty ignored (out_valid=0). Pointers wrap modulo DEPTH.
//  FWFT: out_data/out_err reflect mem[rd_ptr] combinationally from storage; out_valid=(count!=0).
//   First byte visible one cycle after its write edge.
//  framing_error is not stored (receive block does not load a framing-errored byte).
// CONFIGURATION
//  RX_ERR_CNT_EN defined: adds cnt_clr, ferr_cnt, oerr_cnt. Each counter increments on rising
//   edge of framing_error / overrun_error (registered previous value), saturates at all-ones,
//   cnt_clr wins over increment same cycle.
//  RX_ERR_CNT_EN undefined: those ports and registers do not exist; all else identical.
// TESTING
//  Reset: n_rst low mid-READ -> data_read=0, count=0, out_valid=0 immediately (async).
//  Single byte 0xA5, out_ready=0 -> one data_read pulse, count=1, out_data=0xA5, out_err=0.
//  8 bytes 0x00..0x07, no pops -> full=1, 9th data_ready held: no data_read; pop -> 9th captured.
//  Full FIFO, data_ready and out_ready same cycle -> pop only, count 8->7, push next cycle.
//  overrun_error=1 with byte 0x3C -> out_err=1 on that entry only; pops in order 0x3C then next.
//  RX_ERR_CNT_EN: 3 framing_error pulses -> ferr_cnt=3; 300 pulses -> 255; cnt_clr -> 0.

Source files
------------

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo
//   Downstream consumer of the UART receive block. A small capture FSM drains
//   the one-byte receive buffer through the data_ready/data_read handshake
//   into a DEPTH-entry FIFO. Each entry is tagged with the overrun status.
//   Bytes are presented to the host on a first-word-fall-through valid/ready
//   port.
//
// Ports
//   clk, n_rst      system clock (rising edge), asynchronous active-low reset
//   data_ready      receive buffer holds an unread byte
//   rx_data         receive buffer byte
//   overrun_error   receive buffer overwrote an unread byte (stored as tag)
//   framing_error   stop bit failure on the current frame (counted only)
//   data_read       one-cycle pulse: byte consumed from the receive buffer
//   out_data        FIFO head byte (valid when out_valid)
//   out_err         overrun tag stored with the head byte
//   out_valid       FIFO not empty
//   out_ready       host accepts the head; pop when out_valid && out_ready
//   full            count == DEPTH
//   count           entries held, 0..DEPTH
//
// Optional feature, enabled by defining the macro RX_ERR_CNT_EN:
//   cnt_clr         synchronous clear of both error counters
//   ferr_cnt        saturating count of framing_error rising edges
//   oerr_cnt        saturating count of overrun_error rising edges

module rx_byte_fifo #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              data_ready,
    input  logic [7:0]        rx_data,
    input  logic              overrun_error,
    input  logic              framing_error,
    output logic              data_read,
    output logic [7:0]        out_data,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic [ADDR_W:0]   count
`ifdef RX_ERR_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [ERR_CNT_W-1:0] ferr_cnt,
    output logic [ERR_CNT_W-1:0] oerr_cnt
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT
    } cap_state_e;

    cap_state_e          state_q, state_d;
    logic                data_read_q, data_read_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [8:0]          mem_q [DEPTH];
    logic [8:0]          mem_d [DEPTH];

    logic                push;
    logic                pop;
    logic [8:0]          head;

    assign full      = (count_q == FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign data_read = data_read_q;

    // Head entry comes straight from storage so the first byte is visible
    // as soon as its write edge has passed.
    assign head     = mem_q[rd_ptr_q];
    assign out_data = head[7:0];
    assign out_err  = head[8];

    always_comb begin
        // full is the registered count, so a pop in the same cycle never
        // frees a slot for a push until the following edge.
        push = (state_q == ST_IDLE) && data_ready && !full;
        pop  = out_valid && out_ready;

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (push) state_d = ST_READ;
            ST_READ: state_d = ST_WAIT;
            // Hold until the receive block drops data_ready so the byte
            // just taken is never captured twice.
            ST_WAIT: if (!data_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Moore output, registered from the next state.
        data_read_d = (state_d == ST_READ);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {overrun_error, rx_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            data_read_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            data_read_q <= data_read_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

`ifdef RX_ERR_CNT_EN
    logic                 ferr_prev_q, ferr_prev_d;
    logic                 oerr_prev_q, oerr_prev_d;
    logic [ERR_CNT_W-1:0] ferr_cnt_q, ferr_cnt_d;
    logic [ERR_CNT_W-1:0] oerr_cnt_q, oerr_cnt_d;

    assign ferr_cnt = ferr_cnt_q;
    assign oerr_cnt = oerr_cnt_q;

    always_comb begin
        ferr_prev_d = framing_error;
        oerr_prev_d = overrun_error;
        ferr_cnt_d  = ferr_cnt_q;
        oerr_cnt_d  = oerr_cnt_q;

        // Clear has priority; counters saturate at all-ones.
        if (cnt_clr) begin
            ferr_cnt_d = '0;
            oerr_cnt_d = '0;
        end else begin
            if (framing_error && !ferr_prev_q && (ferr_cnt_q != '1))
                ferr_cnt_d = ferr_cnt_q + 1'b1;
            if (overrun_error && !oerr_prev_q && (oerr_cnt_q != '1))
                oerr_cnt_d = oerr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ferr_prev_q <= 1'b0;
            oerr_prev_q <= 1'b0;
            ferr_cnt_q  <= '0;
            oerr_cnt_q  <= '0;
        end else begin
            ferr_prev_q <= ferr_prev_d;
            oerr_prev_q <= oerr_prev_d;
            ferr_cnt_q  <= ferr_cnt_d;
            oerr_cnt_q  <= oerr_cnt_d;
        end
    end
`else
    // framing_error only feeds the error counters; without them it is
    // deliberately left unconnected.
    localparam int unsigned UNUSED_ERR_CNT_W = ERR_CNT_W;
    logic unused_framing_error;
    assign unused_framing_error = framing_error;
`endif

endmodule

// File: tb/tb_rx_byte_fifo.sv
module tb_rx_byte_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       data_ready;
    logic [7:0] rx_data;
    logic       overrun_error;
    logic       framing_error;
    logic       data_read;
    logic [7:0] out_data;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic [3:0] count;
`ifdef RX_ERR_CNT_EN
    logic       cnt_clr;
    logic [7:0] ferr_cnt;
    logic [7:0] oerr_cnt;
`endif

    rx_byte_fifo #(.DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .data_ready    (data_ready),
        .rx_data       (rx_data),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
        .data_read     (data_read),
        .out_data      (out_data),
        .out_err       (out_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .full          (full),
        .count         (count)
`ifdef RX_ERR_CNT_EN
        ,
        .cnt_clr       (cnt_clr),
        .ferr_cnt      (ferr_cnt),
        .oerr_cnt      (oerr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: ordered list of {overrun_tag, byte} the FIFO should hold.
    logic [8:0] q[$];

    // Random-phase receive buffer model state.
    bit         pending;
    int         cool;
    logic [8:0] pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, count, q.size());
        check({tag, "_full"}, full, (q.size() == DEPTH));
        check({tag, "_valid"}, out_valid, (q.size() != 0));
        if (q.size() != 0) begin
            check({tag, "_data"}, out_data, q[0][7:0]);
            check({tag, "_err"}, out_err, q[0][8]);
        end
    endtask

    // Offer one byte while the FIFO has room; capture must be immediate.
    task automatic send_byte(input logic [7:0] b, input logic err);
        bit seen = 0;
        int n = 0;
        data_ready = 1'b1;
        rx_data = b;
        overrun_error = err;
        while (!seen && n < 20) begin
            step();
            n++;
            if (data_read === 1'b1) seen = 1;
        end
        check("cap_seen", seen, 1);
        check("cap_latency", n, 1);
        if (seen) q.push_back({err, b});
        check_state("cap");
        data_ready = 1'b0;
        overrun_error = 1'b0;
        step();
        check("dr_single1", data_read, 1'b0);
        step();
        check("dr_single2", data_read, 1'b0);
    endtask

    task automatic pop_one();
        check_state("pop_pre");
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check_state("pop_post");
    endtask

    task automatic rnd_cycle(input bit allow_new, input int pop_pct);
        bit was_pending;
        bit do_pop;
        int pre_size;
        if (allow_new && !pending && cool == 0 && $urandom_range(0, 2) == 0) begin
            pending = 1;
            pend = {($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 8'($urandom)};
            data_ready = 1'b1;
            rx_data = pend[7:0];
            overrun_error = pend[8];
        end
        out_ready = ($urandom_range(0, 99) < pop_pct) ? 1'b1 : 1'b0;
        was_pending = pending;
        pre_size = q.size();
        do_pop = (pre_size != 0) && out_ready;
        step();
        if (do_pop) void'(q.pop_front());
        check("rnd_data_read", data_read, (was_pending && pre_size != DEPTH));
        if (data_read === 1'b1 && was_pending) begin
            q.push_back(pend);
            pending = 0;
            data_ready = 1'b0;
            overrun_error = 1'b0;
            cool = 2;
        end else if (!pending && cool > 0) begin
            cool--;
        end
        check_state("rnd");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        data_ready = 1'b0;
        rx_data = 8'h00;
        overrun_error = 1'b0;
        framing_error = 1'b0;
        out_ready = 1'b0;
`ifdef RX_ERR_CNT_EN
        cnt_clr = 1'b0;
`endif
        step();
        step();
        check("rst_data_read", data_read, 1'b0);
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_err", out_err, 1'b0);
        n_rst = 1'b1;
        step();

        // Reset asserted while data_read is high
        data_ready = 1'b1;
        rx_data = 8'h11;
        step();
        check("midread_pulse", data_read, 1'b1);
        check("midread_count", count, 1);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_data_read", data_read, 1'b0);
        check("async_rst_count", count, 0);
        check("async_rst_valid", out_valid, 1'b0);
        data_ready = 1'b0;
        step();
        n_rst = 1'b1;
        step();
        q.delete();
        check_state("after_rst");
        check("after_rst_dr", data_read, 1'b0);

        // Single byte, host not ready
        send_byte(8'hA5, 1'b0);
        check("single_data", out_data, 8'hA5);
        pop_one();

        // Simultaneous push and pop with one entry held
        send_byte(8'h5A, 1'b0);
        data_ready = 1'b1;
        rx_data = 8'h66;
        out_ready = 1'b1;
        step();
        void'(q.pop_front());
        q.push_back({1'b0, 8'h66});
        check("pp_data_read", data_read, 1'b1);
        check_state("pp");
        out_ready = 1'b0;
        data_ready = 1'b0;
        step();
        step();
        pop_one();

        // Pop on empty is ignored
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_state("empty_pop");

        // Fill to full
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0);
        check("fill_full", full, 1'b1);

        // Ninth byte held off while full
        data_ready = 1'b1;
        rx_data = 8'h08;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_no_read", data_read, 1'b0);
            check_state("full_hold");
        end

        // Pop while full and data_ready: pop only, push next cycle
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        void'(q.pop_front());
        check("full_pop_no_read", data_read, 1'b0);
        check_state("full_pop");
        step();
        check("ninth_read", data_read, 1'b1);
        q.push_back({1'b0, 8'h08});
        check_state("ninth");
        data_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < DEPTH; i++) pop_one();

        // Overrun tag follows only its own entry
        send_byte(8'h3C, 1'b1);
        send_byte(8'h4D, 1'b0);
        check("ovr_head_err", out_err, 1'b1);
        check("ovr_head_data", out_data, 8'h3C);
        pop_one();
        check("ovr_next_err", out_err, 1'b0);
        check("ovr_next_data", out_data, 8'h4D);
        pop_one();

        // Randomised traffic against the queue model
        pending = 0;
        cool = 0;
        for (int c = 0; c < 200; c++) rnd_cycle(1, 20);
        for (int c = 0; c < 200; c++) rnd_cycle(1, 75);
        for (int c = 0; c < 40; c++) rnd_cycle(0, 100);
        check("drain_empty", out_valid, 1'b0);

`ifdef RX_ERR_CNT_EN
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_clr_f", ferr_cnt, 8'd0);
        check("cnt_clr_o", oerr_cnt, 8'd0);
        for (int i = 0; i < 3; i++) begin
            framing_error = 1'b1;
            step();
            framing_error = 1'b0;
            step();
        end
        check("ferr_3", ferr_cnt, 8'd3);
        check("oerr_0", oerr_cnt, 8'd0);
        framing_error = 1'b1;
        for (int i = 0; i < 5; i++) step();
        framing_error = 1'b0;
        step();
        check("ferr_level", ferr_cnt, 8'd4);
        for (int i = 0; i < 2; i++) begin
            overrun_error = 1'b1;
            step();
            overrun_error = 1'b0;
            step();
        end
        check("oerr_2", oerr_cnt, 8'd2);
        for (int i = 0; i < 300; i++) begin
            framing_error = 1'b1;
            step();
            framing_error = 1'b0;
            step();
        end
        check("ferr_sat", ferr_cnt, 8'd255);
        framing_error = 1'b1;
        cnt_clr = 1'b1;
        step();
        framing_error = 1'b0;
        cnt_clr = 1'b0;
        check("clr_wins_f", ferr_cnt, 8'd0);
        check("clr_wins_o", oerr_cnt, 8'd0);
        step();
        check("clr_hold_f", ferr_cnt, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
